mmio_bus_bridge: RTL and testbench

//  Parametrised memory-mapped bridge between the furv core data port and N slaves (RAM, LED, future peripherals).

---
 rtl/myrv_bus_pkg.sv | 20 ++
 rtl/mmio_addr_decode.sv | 44 ++++
 rtl/mmio_bus_bridge.sv | 179 +++++++++++++++++
 tb/tb_mmio_bus_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myrv_bus_pkg.sv
// Shared types and constants for the furv MMIO bus bridge.
// Imported by the address decoder and the bridge top level.
package myrv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RESP,
        ST_WR
    } bus_state_e;

    localparam int          SIZE_LOG2_W   = 6;
    localparam int          N_SLAVES_MAX  = 8;
    localparam logic [31:0] ERR_DATA_DFLT = 32'h0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Table-driven slave decoder: power-of-two regions, lowest index wins.
// Purely combinational; returns one-hot hit, slave index and offset.
module mmio_addr_decode
    import myrv_bus_pkg::*;
#(
    parameter int                              N_SLAVES  = 4,
    parameter int                              ADDR_W    = 32,
    parameter int                              IDX_W     = 2,
    parameter logic [N_SLAVES*ADDR_W-1:0]      BASE      = '0,
    parameter logic [N_SLAVES*SIZE_LOG2_W-1:0] SIZE_LOG2 = '0
) (
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [N_SLAVES-1:0] o_hit,
    output logic                o_any,
    output logic [IDX_W-1:0]    o_idx,
    output logic [ADDR_W-1:0]   o_offset
);

    logic [SIZE_LOG2_W-1:0] w_size;
    logic [ADDR_W-1:0]      w_base;

    // Walk from the top so the lowest matching index is the last writer.
    always_comb begin
        o_hit    = '0;
        o_any    = 1'b0;
        o_idx    = '0;
        o_offset = '0;
        w_size   = '0;
        w_base   = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            w_size = SIZE_LOG2[i*SIZE_LOG2_W +: SIZE_LOG2_W];
            w_base = BASE[i*ADDR_W +: ADDR_W];
            if ((w_size != '0) &&
                ((i_addr >> w_size) == (w_base >> w_size))) begin
                o_hit    = '0;
                o_hit[i] = 1'b1;
                o_any    = 1'b1;
                o_idx    = IDX_W'(i);
                o_offset = i_addr - w_base;
            end
        end
    end

endmodule

// File: rtl/mmio_bus_bridge.sv
// Core data port to N memory-mapped slaves: decode, registered read
// handshake with per-slave ack, timeout watchdog and sticky bus error.
module mmio_bus_bridge
    import myrv_bus_pkg::*;
#(
    parameter int                              N_SLAVES  = 4,
    parameter int                              DATA_W    = 32,
    parameter int                              ADDR_W    = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0]      BASE      =
        {ADDR_W'(0), ADDR_W'(0), ADDR_W'('h100), ADDR_W'('h400)},
    parameter logic [N_SLAVES*SIZE_LOG2_W-1:0] SIZE_LOG2 =
        {6'd0, 6'd0, 6'd8, 6'd2},
    parameter int                              TIMEOUT   = 16,
    parameter logic [DATA_W-1:0]               ERR_DATA  =
        DATA_W'(ERR_DATA_DFLT)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic [DATA_W-1:0]            i_data_out,
    input  logic                         i_mem_en,
    input  logic                         i_mem_read,
    output logic [DATA_W-1:0]            o_data_in,
    output logic                         o_read_ack,
    output logic                         o_wr_ack,
    output logic [N_SLAVES-1:0]          o_s_sel,
    output logic                         o_s_read,
    output logic                         o_s_write,
    output logic [ADDR_W-1:0]            o_s_addr,
    output logic [DATA_W-1:0]            o_s_wdata,
    input  logic [N_SLAVES*DATA_W-1:0]   i_s_rdata,
    input  logic [N_SLAVES-1:0]          i_s_ack,
    output logic                         o_bus_err,
    output logic [ADDR_W-1:0]            o_err_addr
);

    localparam int IDX_W = idx_width(N_SLAVES);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    if (N_SLAVES < 1 || N_SLAVES > N_SLAVES_MAX) begin : g_bad_cfg
        $error("mmio_bus_bridge: N_SLAVES out of range");
    end

    logic [N_SLAVES-1:0] w_hit;
    logic                w_any;
    logic [IDX_W-1:0]    w_idx;
    logic [ADDR_W-1:0]   w_offset;
    logic                w_ack;
    logic [DATA_W-1:0]   w_rdata;

    bus_state_e          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [TMR_W-1:0]    r_timer;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data_in;
    logic                r_read_ack;
    logic                r_wr_ack;
    logic [N_SLAVES-1:0] r_s_sel;
    logic                r_s_read;
    logic                r_s_write;
    logic [ADDR_W-1:0]   r_s_addr;
    logic [DATA_W-1:0]   r_s_wdata;
    logic                r_bus_err;
    logic [ADDR_W-1:0]   r_err_addr;

    mmio_addr_decode #(
        .N_SLAVES  (N_SLAVES),
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W),
        .BASE      (BASE),
        .SIZE_LOG2 (SIZE_LOG2)
    ) u_decode (
        .i_addr   (i_addr),
        .o_hit    (w_hit),
        .o_any    (w_any),
        .o_idx    (w_idx),
        .o_offset (w_offset)
    );

    // Only the latched slave's ack and data are ever looked at.
    assign w_ack   = i_s_ack[r_idx];
    assign w_rdata = i_s_rdata[r_idx*DATA_W +: DATA_W];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_timer    <= '0;
            r_addr     <= '0;
            r_data_in  <= '0;
            r_read_ack <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_s_sel    <= '0;
            r_s_read   <= 1'b0;
            r_s_write  <= 1'b0;
            r_s_addr   <= '0;
            r_s_wdata  <= '0;
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_read_ack <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_s_write  <= 1'b0;
            r_data_in  <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_mem_en) begin
                        r_addr   <= i_addr;
                        r_s_sel  <= w_hit;
                        r_s_addr <= w_offset;
                        r_idx    <= w_idx;
                        r_timer  <= '0;
                        if (!w_any) begin
                            r_bus_err <= 1'b1;
                            if (!r_bus_err) begin
                                r_err_addr <= i_addr;
                            end
                        end
                        if (i_mem_read && w_any) begin
                            r_s_read <= 1'b1;
                            r_state  <= ST_RD_REQ;
                        end else if (i_mem_read) begin
                            r_data_in  <= ERR_DATA;
                            r_read_ack <= 1'b1;
                            r_state    <= ST_RESP;
                        end else begin
                            r_s_wdata <= i_data_out;
                            r_s_write <= w_any;
                            r_wr_ack  <= 1'b1;
                            r_state   <= ST_WR;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (w_ack || r_timer == TMR_LAST) begin
                        r_s_read   <= 1'b0;
                        r_s_sel    <= '0;
                        r_read_ack <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                    if (w_ack) begin
                        r_data_in <= w_rdata;
                    end else if (r_timer == TMR_LAST) begin
                        r_data_in <= ERR_DATA;
                        r_bus_err <= 1'b1;
                        if (!r_bus_err) begin
                            r_err_addr <= r_addr;
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                ST_WR: begin
                    r_s_sel <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data_in  = r_data_in;
    assign o_read_ack = r_read_ack;
    assign o_wr_ack   = r_wr_ack;
    assign o_s_sel    = r_s_sel;
    assign o_s_read   = r_s_read;
    assign o_s_write  = r_s_write;
    assign o_s_addr   = r_s_addr;
    assign o_s_wdata  = r_s_wdata;
    assign o_bus_err  = r_bus_err;
    assign o_err_addr = r_err_addr;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Bench for mmio_bus_bridge: transaction-level model with per-cycle
// expected outputs, plus literal latency/data checks for each scenario.
module tb_mmio_bus_bridge;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;
    localparam logic [NS*AW-1:0] P_BASE = {32'h0, 32'h0, 32'h100, 32'h400};
    localparam logic [NS*6-1:0]  P_SIZE = {6'd0, 6'd0, 6'd8, 6'd2};
    localparam logic [NS*AW-1:0] O_BASE = {32'h0, 32'h0, 32'h100, 32'h100};
    localparam logic [NS*6-1:0]  O_SIZE = {6'd0, 6'd0, 6'd8, 6'd8};
    localparam logic [31:0]      ERRD   = 32'h0;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [AW-1:0]  addr = '0;
    logic [DW-1:0]  data_out = '0;
    logic           mem_en = 1'b0;
    logic           mem_read = 1'b0;
    logic [NS*DW-1:0] s_rdata = '0;
    logic [NS-1:0]  s_ack = '0;

    logic [DW-1:0]  o_data_in, ov_data_in;
    logic           o_read_ack, ov_read_ack;
    logic           o_wr_ack, ov_wr_ack;
    logic [NS-1:0]  o_s_sel, ov_s_sel;
    logic           o_s_read, ov_s_read;
    logic           o_s_write, ov_s_write;
    logic [AW-1:0]  o_s_addr, ov_s_addr;
    logic [DW-1:0]  o_s_wdata, ov_s_wdata;
    logic           o_bus_err, ov_bus_err;
    logic [AW-1:0]  o_err_addr, ov_err_addr;

    mmio_bus_bridge #(
        .N_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW), .BASE(P_BASE),
        .SIZE_LOG2(P_SIZE), .TIMEOUT(TO), .ERR_DATA(ERRD)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_data_out(data_out),
        .i_mem_en(mem_en), .i_mem_read(mem_read), .o_data_in(o_data_in),
        .o_read_ack(o_read_ack), .o_wr_ack(o_wr_ack), .o_s_sel(o_s_sel),
        .o_s_read(o_s_read), .o_s_write(o_s_write), .o_s_addr(o_s_addr),
        .o_s_wdata(o_s_wdata), .i_s_rdata(s_rdata), .i_s_ack(s_ack),
        .o_bus_err(o_bus_err), .o_err_addr(o_err_addr)
    );

    mmio_bus_bridge #(
        .N_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW), .BASE(O_BASE),
        .SIZE_LOG2(O_SIZE), .TIMEOUT(TO), .ERR_DATA(ERRD)
    ) u_ovl (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_data_out(data_out),
        .i_mem_en(mem_en), .i_mem_read(mem_read), .o_data_in(ov_data_in),
        .o_read_ack(ov_read_ack), .o_wr_ack(ov_wr_ack), .o_s_sel(ov_s_sel),
        .o_s_read(ov_s_read), .o_s_write(ov_s_write), .o_s_addr(ov_s_addr),
        .o_s_wdata(ov_s_wdata), .i_s_rdata(s_rdata), .i_s_ack(s_ack),
        .o_bus_err(ov_bus_err), .o_err_addr(ov_err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0]  sel;
        logic        rd;
        logic        wr;
        logic        rack;
        logic        wack;
        logic [31:0] din;
        logic [31:0] saddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[int];
    logic [31:0] err_evt[int];
    bit          rst_evt[int];
    exp_t        ce;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_on = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_err_addr = '0;

    logic [31:0] m_base[NS] = '{32'h400, 32'h100, 32'h0, 32'h0};
    int          m_size[NS] = '{2, 8, 0, 0};

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Region membership by plain range arithmetic; first slave listed wins.
    function automatic bit m_dec(input logic [31:0] a, output int idx,
                                 output logic [31:0] off);
        idx = 0;
        off = '0;
        for (int i = 0; i < NS; i++) begin
            if (m_size[i] != 0 && a >= m_base[i] &&
                (longint'(a) - longint'(m_base[i])) <
                (longint'(1) << m_size[i])) begin
                idx = i;
                off = a - m_base[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            if (rst_evt.exists(cyc)) begin
                m_err = 1'b0;
                m_err_addr = '0;
            end
            if (err_evt.exists(cyc)) begin
                if (!m_err) m_err_addr = err_evt[cyc];
                m_err = 1'b1;
            end
            ce = exp_q.exists(cyc) ? exp_q[cyc] : '0;
            check("s_sel", 32'(o_s_sel), 32'(ce.sel));
            check("s_read", 32'(o_s_read), 32'(ce.rd));
            check("s_write", 32'(o_s_write), 32'(ce.wr));
            check("read_ack", 32'(o_read_ack), 32'(ce.rack));
            check("wr_ack", 32'(o_wr_ack), 32'(ce.wack));
            check("data_in", o_data_in, ce.din);
            if (ce.sel != '0) check("s_addr", o_s_addr, ce.saddr);
            if (ce.wr) check("s_wdata", o_s_wdata, ce.wdata);
            check("bus_err", 32'(o_bus_err), 32'(m_err));
            check("err_addr", o_err_addr, m_err_addr);
        end
    end

    int          rack_cyc = 0, wack_cyc = 0, rack_cnt = 0;
    logic [31:0] rack_data = '0, wr_data = '0, rd_saddr = '0, ov_data = '0;
    logic [3:0]  wr_sel = '0, ov_sel = '0;
    logic        wr_strobe = 1'b0;

    always @(negedge clk) begin
        if (o_read_ack) begin
            rack_cyc  = cyc;
            rack_data = o_data_in;
            rack_cnt++;
        end
        if (o_wr_ack) begin
            wack_cyc  = cyc;
            wr_sel    = o_s_sel;
            wr_data   = o_s_wdata;
            wr_strobe = o_s_write;
        end
        if (o_s_read) rd_saddr = o_s_addr;
        if (ov_s_read) ov_sel = ov_s_sel;
        if (ov_read_ack) ov_data = ov_data_in;
    end

    // dly: RD_REQ cycle carrying the ack (<0: never); rst_in: RD_REQ cycle
    // in which reset is raised (<0: none); poke: stray mem_en mid-read.
    task automatic do_read(input logic [31:0] a, input int dly,
                           input logic [3:0] noise, input int rst_in,
                           input bit poke, output int k);
        int          idx, n;
        logic [31:0] off;
        bit          hit, acked;
        exp_t        e;
        k = cyc;
        hit = m_dec(a, idx, off);
        acked = hit && dly >= 0 && dly < TO;
        n = !hit ? 0 : (acked ? dly + 1 : TO);
        for (int j = 1; j <= n; j++) begin
            e = '0;
            e.sel = 4'(1 << idx);
            e.rd = 1'b1;
            e.saddr = off;
            exp_q[k+j] = e;
        end
        e = '0;
        e.rack = 1'b1;
        e.din = acked ? s_rdata[idx*32 +: 32] : ERRD;
        exp_q[k+n+1] = e;
        if (!acked) err_evt[k+n+1] = a;
        addr = a;
        mem_read = 1'b1;
        mem_en = 1'b1;
        step();
        mem_en = 1'b0;
        for (int j = 0; j < n; j++) begin
            s_ack = (acked && j == dly) ? 4'b0011 : noise;
            if (poke && j == 3) begin
                mem_en = 1'b1;
                mem_read = 1'b0;
            end else begin
                mem_en = 1'b0;
                mem_read = 1'b1;
            end
            if (j == rst_in) begin
                rst = 1'b1;
                for (int c = k + j + 2; c <= k + n + 1; c++) begin
                    if (exp_q.exists(c)) exp_q.delete(c);
                    if (err_evt.exists(c)) err_evt.delete(c);
                end
                rst_evt[k+j+2] = 1'b1;
                step();
                rst = 1'b0;
                s_ack = '0;
                step();
                return;
            end
            step();
        end
        mem_en = 1'b0;
        mem_read = 1'b1;
        s_ack = 4'hF;
        step();
        s_ack = '0;
        step();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            output int k);
        int          idx;
        logic [31:0] off;
        exp_t        e;
        k = cyc;
        e = '0;
        e.wack = 1'b1;
        if (m_dec(a, idx, off)) begin
            e.sel = 4'(1 << idx);
            e.wr = 1'b1;
            e.saddr = off;
            e.wdata = d;
        end else begin
            err_evt[k+1] = a;
        end
        exp_q[k+1] = e;
        addr = a;
        data_out = d;
        mem_read = 1'b0;
        mem_en = 1'b1;
        step();
        mem_en = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, rc;
        s_rdata = {32'hDEAD0003, 32'h33330002, 32'hCAFE0001, 32'h11110000};
        step();
        step();
        check("rst s_sel", 32'(o_s_sel), 32'h0);
        check("rst read_ack", 32'(o_read_ack), 32'h0);
        check("rst wr_ack", 32'(o_wr_ack), 32'h0);
        check("rst strobes", 32'({o_s_read, o_s_write}), 32'h0);
        check("rst data_in", o_data_in, 32'h0);
        check("rst bus_err", 32'(o_bus_err), 32'h0);
        check("rst err_addr", o_err_addr, 32'h0);
        rst = 1'b0;
        chk_on = 1'b1;
        step();

        s_ack = 4'hF;
        step();
        s_ack = '0;
        step();

        do_read(32'h104, 0, 4'h0, -1, 1'b0, k);
        check("t1 latency", 32'(rack_cyc - k), 32'd2);
        check("t1 data", rack_data, 32'hCAFE0001);
        check("t1 s_addr", rd_saddr, 32'h4);

        do_write(32'h400, 32'h5, k);
        check("t2 latency", 32'(wack_cyc - k), 32'd1);
        check("t2 s_sel", 32'(wr_sel), 32'h1);
        check("t2 s_write", 32'(wr_strobe), 32'h1);
        check("t2 s_wdata", wr_data, 32'h5);
        check("t2 bus_err", 32'(o_bus_err), 32'h0);

        do_write(32'h403, 32'hA5, k);
        check("edge s_sel", 32'(wr_sel), 32'h1);

        do_read(32'h104, -1, 4'h0, -1, 1'b1, k);
        check("t4 latency", 32'(rack_cyc - k), 32'd17);
        check("t4 data", rack_data, 32'h0);
        check("t4 bus_err", 32'(o_bus_err), 32'h1);
        check("t4 err_addr", o_err_addr, 32'h104);

        rst = 1'b1;
        rst_evt[cyc+1] = 1'b1;
        step();
        rst = 1'b0;
        step();

        do_read(32'h800, 0, 4'h0, -1, 1'b0, k);
        check("t3 latency", 32'(rack_cyc - k), 32'd1);
        check("t3 data", rack_data, 32'h0);
        check("t3 bus_err", 32'(o_bus_err), 32'h1);
        check("t3 err_addr", o_err_addr, 32'h800);
        do_write(32'h900, 32'h7, k);
        check("t3 sticky addr", o_err_addr, 32'h800);

        do_read(32'h110, 1, 4'b0100, -1, 1'b0, k);
        check("t5 latency", 32'(rack_cyc - k), 32'd3);
        check("t5 main data", rack_data, 32'hCAFE0001);
        check("t5 s_addr", rd_saddr, 32'h10);
        check("t5 ovl sel", 32'(ov_sel), 32'h1);
        check("t5 ovl data", ov_data, 32'h11110000);

        rc = rack_cnt;
        do_read(32'h104, 0, 4'h0, 0, 1'b0, k);
        check("t6 no read_ack", 32'(rack_cnt - rc), 32'd0);
        check("t6 bus_err", 32'(o_bus_err), 32'h0);
        s_rdata[63:32] = 32'hBEEF0002;
        do_read(32'h1FC, 0, 4'h0, -1, 1'b0, k);
        check("t6 latency", 32'(rack_cyc - k), 32'd2);
        check("t6 data", rack_data, 32'hBEEF0002);
        check("t6 s_addr", rd_saddr, 32'hFC);

        do_read(32'h200, 0, 4'h0, -1, 1'b0, k);
        check("edge err_addr", o_err_addr, 32'h200);

        step();
        step();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
